// File: rtl/mdu_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative multiply/divide unit owning the HI/LO registers.
//               One shift-add or restoring-divide step per cycle; WIDTH
//               cycles per operation. Supplies a pipeline stall while an
//               HI/LO access collides with a running operation.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;   // 1: divide, 0: multiply
    logic             r_neg_q;    // negate product / quotient at the end
    logic             r_neg_r;    // negate remainder (dividend sign)
    logic             r_div0;     // divisor was zero
    logic [WIDTH-1:0] r_u;        // product upper half / partial remainder
    logic [WIDTH-1:0] r_a;        // multiplier / dividend, shifted each step
    logic [WIDTH-1:0] r_b;        // multiplicand / divisor magnitude
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Operand sign extraction and magnitude for the signed variants
    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_signed = ~op[0];
    assign w_sa     = w_signed & srcA[WIDTH-1];
    assign w_sb     = w_signed & srcB[WIDTH-1];
    assign w_abs_a  = w_sa ? (~srcA + 1'b1) : srcA;
    assign w_abs_b  = w_sb ? (~srcB + 1'b1) : srcB;

    // Multiply step: conditional add into the upper half, then shift right
    logic [WIDTH:0]   w_msum;
    logic [WIDTH-1:0] w_mu_nx;
    logic [WIDTH-1:0] w_ma_nx;

    assign w_msum  = {1'b0, r_u} + {1'b0, (r_a[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mu_nx = w_msum[WIDTH:1];
    assign w_ma_nx = {w_msum[0], r_a[WIDTH-1:1]};

    // Restoring divide step: shift in next dividend bit, trial subtract
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_du_nx;
    logic [WIDTH-1:0] w_da_nx;

    assign w_t     = {r_u, r_a[WIDTH-1]};
    assign w_diff  = w_t - {1'b0, r_b};
    assign w_ge    = (w_t >= {1'b0, r_b});
    assign w_du_nx = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_da_nx = {r_a[WIDTH-2:0], w_ge};

    logic [WIDTH-1:0] w_u_nx;
    logic [WIDTH-1:0] w_a_nx;

    assign w_u_nx = r_is_div ? w_du_nx : w_mu_nx;
    assign w_a_nx = r_is_div ? w_da_nx : w_ma_nx;

    // Final sign correction applied on the last step's values.
    // With a zero divisor every trial subtract succeeds, so the remainder
    // path ends holding |dividend|; re-signing it restores srcA as issued.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_f;
    logic [WIDTH-1:0]   w_q_f;
    logic [WIDTH-1:0]   w_r_f;
    logic [WIDTH-1:0]   w_hi_f;
    logic [WIDTH-1:0]   w_lo_f;

    assign w_prod   = {w_mu_nx, w_ma_nx};
    assign w_prod_f = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_q_f    = r_div0  ? {WIDTH{1'b1}}
                    : (r_neg_q ? (~w_da_nx + 1'b1) : w_da_nx);
    assign w_r_f    = r_neg_r ? (~w_du_nx + 1'b1) : w_du_nx;
    assign w_hi_f   = r_is_div ? w_r_f : w_prod_f[2*WIDTH-1:WIDTH];
    assign w_lo_f   = r_is_div ? w_q_f : w_prod_f[WIDTH-1:0];

    // Control FSM, datapath iteration and HI/LO register updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_u      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        r_u      <= '0;
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_is_div <= op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_div0   <= (srcB == '0);
                        r_cnt    <= C_CNT_INIT;
                        r_state  <= S_RUN;
                    end else begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_u   <= w_u_nx;
                        r_a   <= w_a_nx;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_hi    <= w_hi_f;
                            r_lo    <= w_lo_f;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == S_RUN);
    assign stall = busy & (start | rd_hilo | mthi | mtlo);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Scoreboard bench for mdu_iter: issued ops push expected
//               {hi,lo}; a monitor pops and compares on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         cancel;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         rd_hilo;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    mdu_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .cancel  (cancel),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one op, expect busy for exactly W cycles and a one-cycle done
    task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int cnt;
        @(posedge clk); #1;
        op = o; srcA = a; srcB = b; start = 1'b1;
        exp_q.push_back({ehi, elo});
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        check({name, " busy_cycles"}, 64'(cnt), 64'(W));
        @(negedge clk);
        check({name, " done_width"}, 64'(done), 64'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle_timeout"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit bad;
        reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_hilo = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual hi=%h lo=%h required no done", hi, lo);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("result_hilo", {hi, lo}, mon_exp);
                    end
                end
            end
        join_none

        #2;
        check("reset busy",  64'(busy),  64'd0);
        check("reset done",  64'(done),  64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset hilo",  {hi, lo},   64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        issue("multu_7x6",    2'b01, 32'd7,        32'd6,        32'h0,        32'h2A);
        issue("mult_m3x5",    2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        issue("mult_minsq",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        issue("div_m7d2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        issue("div_7dm2",     2'b10, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD);
        issue("div_min_m1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        issue("divu_5d0",     2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        issue("div_m7d0",     2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);

        // MTHI / MTLO in IDLE
        @(posedge clk); #1;
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        check("mthi stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo both", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);

        // Read in IDLE does not stall
        rd_hilo = 1'b1; #1;
        check("idle rd stall", 64'(stall), 64'd0);
        rd_hilo = 1'b0;

        // cancel beats start in IDLE
        @(posedge clk); #1;
        op = 2'b01; srcA = 32'd3; srcB = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("cancel_prio busy", 64'(busy), 64'd0);

        // DIVU 100/7 with an MTHI attempt mid-run (stalled, ignored)
        @(posedge clk); #1;
        op = 2'b11; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mthi = 1'b1; wdata = 32'hDEAD;
        #1;
        check("run mthi stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        mthi = 1'b0;
        wait_idle("divu_100d7");
        check("divu_100d7 hi", 64'(hi), 64'd2);

        // MULT 3*-4 with MFLO issued 3 cycles after start
        @(posedge clk); #1;
        op = 2'b00; srcA = 32'd3; srcB = 32'hFFFFFFFC; start = 1'b1;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF4});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd_hilo = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                if (!stall) bad = 1'b1;
            end else break;
        end
        check("rd stall_while_busy", 64'(bad), 64'd0);
        check("rd busy_fell", 64'(busy), 64'd0);
        check("rd stall_released", 64'(stall), 64'd0);
        check("rd new_lo", 64'(lo), 64'hFFFFFFF4);
        rd_hilo = 1'b0;

        // cancel at cycle 10 of MULTU: hi/lo unchanged, no done
        @(posedge clk); #1;
        op = 2'b01; srcA = 32'h1234; srcB = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF4);
        check("cancel done", 64'(done), 64'd0);
        repeat (W + 5) @(negedge clk);

        // asynchronous reset mid-DIVU at cycle 15
        @(posedge clk); #1;
        op = 2'b11; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("areset hilo", {hi, lo}, 64'd0);
        check("areset busy", 64'(busy), 64'd0);
        check("areset done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        issue("multu_after_reset", 2'b01, 32'h10000, 32'h10000, 32'h1, 32'h0);

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
